// File: rtl/pipelined_add_sub_pkg.sv
// Shared defaults and helpers for the pipelined adder/subtractor.
package pipelined_add_sub_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // Two's complement overflow: operands agree in sign but the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// Operand/result streaming bus of the pipelined adder/subtractor.
// A beat moves on a rising edge where valid & ready are both high; the sender
// holds valid and payload stable until that edge, and ready never depends on valid.
interface pipelined_add_sub_if #(parameter int WIDTH = pipelined_add_sub_pkg::DEFAULT_WIDTH) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/pipelined_add_sub_add_slice.sv
// Combinational SLICE-bit ripple adder made of full-adder cells.
module add_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < SLICE; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit add/sub split into STAGES carry-chained slices, one slice per clock,
// with a single global stall driven by the output handshake.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input logic                clk,
  input logic                rst_n,
  pipelined_add_sub_if.slave bus
);

  localparam int SLICE = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_width_check
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
  end

  logic en;
  logic top_am, top_bm;
  logic last_am, last_bm;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet consumed shrink by one slice per stage.
    localparam int CUR = WIDTH - k * SLICE;
    localparam int LO  = (k + 1) * SLICE;

    logic [CUR-1:0]   a_cur, b_cur;
    logic             c_cur, v_cur;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic [LO-1:0]    s_next, s_q;
    logic             c_q, v_q;

    if (k == 0) begin : g_first
      assign a_cur  = bus.a;
      assign b_cur  = bus.op_sub ? ~bus.b : bus.b;
      assign c_cur  = bus.op_sub ? ~bus.cin : bus.cin;
      assign v_cur  = bus.in_valid;
      assign s_next = slice_sum;
    end else begin : g_next
      assign a_cur  = g_stage[k-1].g_hi.a_q;
      assign b_cur  = g_stage[k-1].g_hi.b_q;
      assign c_cur  = g_stage[k-1].c_q;
      assign v_cur  = g_stage[k-1].v_q;
      assign s_next = {slice_sum, g_stage[k-1].s_q};
    end

    add_slice #(.SLICE(SLICE)) u_slice (
      .a    (a_cur[SLICE-1:0]),
      .b    (b_cur[SLICE-1:0]),
      .cin  (c_cur),
      .sum  (slice_sum),
      .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (en) begin
        s_q <= s_next;
        c_q <= slice_cout;
        v_q <= v_cur;
      end
    end

    if (k < STAGES - 1) begin : g_hi
      logic [CUR-SLICE-1:0] a_q, b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_cur[CUR-1:SLICE];
          b_q <= b_cur[CUR-1:SLICE];
        end
      end
    end else begin : g_last
      assign top_am = a_cur[CUR-1];
      assign top_bm = b_cur[CUR-1];
    end
  end

  // Operand sign bits ride alongside the final slice for the overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_am <= 1'b0;
      last_bm <= 1'b0;
    end else if (en) begin
      last_am <= top_am;
      last_bm <= top_bm;
    end
  end

  assign en            = !g_stage[STAGES-1].v_q || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.sum       = g_stage[STAGES-1].s_q;
  assign bus.cout      = g_stage[STAGES-1].c_q;
  assign bus.ovf       = signed_ovf(last_am, last_bm, g_stage[STAGES-1].s_q[WIDTH-1]);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench: directed vector table, streaming scoreboard, stall,
// mid-flight reset, and the STAGES=1 / WIDTH=32,STAGES=8 builds.
module tb_pipelined_add_sub;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int WW = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  pipelined_add_sub_if #(.WIDTH(W))  bus  ();
  pipelined_add_sub_if #(.WIDTH(WW)) bus1 ();
  pipelined_add_sub_if #(.WIDTH(WW)) bus8 ();

  pipelined_add_sub #(.WIDTH(W),  .STAGES(S)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipelined_add_sub #(.WIDTH(WW), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipelined_add_sub #(.WIDTH(WW), .STAGES(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // Both wide builds see the same operand stream and never stall.
  logic          w_valid = 1'b0, w_cin = 1'b0, w_op = 1'b0;
  logic [WW-1:0] w_a = '0, w_b = '0;
  assign bus1.in_valid = w_valid;  assign bus8.in_valid = w_valid;
  assign bus1.a = w_a;             assign bus8.a = w_a;
  assign bus1.b = w_b;             assign bus8.b = w_b;
  assign bus1.cin = w_cin;         assign bus8.cin = w_cin;
  assign bus1.op_sub = w_op;       assign bus8.op_sub = w_op;
  assign bus1.out_ready = 1'b1;    assign bus8.out_ready = 1'b1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  bit mon_en = 1'b0;
  int n_out = 0, first_t = 0, last_t = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: {cout, ovf, sum} from integer arithmetic.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic op);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int ci = cin ? 1 : 0;
    int r, sr;
    logic c, o;
    if (!op) begin
      r = ua + ub + ci; c = (r > 65535);      sr = sa + sb + ci;
    end else begin
      r = ua - ub - ci; c = (ua >= ub + ci);  sr = sa - sb - ci;
    end
    o = (sr > 32767) || (sr < -32768);
    return {c, o, r[15:0]};
  endfunction

  always @(negedge clk) begin
    if (mon_en && rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_beat: got result %h, expected no beat", bus.sum);
      end else begin
        check("stream_result", {bus.cout, bus.ovf, bus.sum}, exp_q.pop_front());
      end
      if (n_out == 0) first_t = cyc;
      last_t = cyc;
      n_out++;
    end
  end

  // ---------------- drivers ----------------
  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic op);
    bit ok = 1'b0;
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.cin = cin; bus.op_sub = op;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    check("send_accept", 64'(ok), 64'd1);
    if (ok) exp_q.push_back(model16(a, b, cin, op));
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin done = 1'b1; break; end
    end
    check("drain", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  // One beat into an idle pipe: out_valid must rise on the STAGES-th edge,
  // counting the accepting edge as the first.
  task automatic run_vec(input vec_t v);
    bus.in_valid = 1'b1; bus.a = v.a; bus.b = v.b; bus.cin = v.cin; bus.op_sub = v.op;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (S - 2) @(posedge clk);
    #1;
    check("latency_early", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("latency_valid", 64'(bus.out_valid), 64'd1);
    check("vec_sum",  64'(bus.sum),  64'(v.sum));
    check("vec_cout", 64'(bus.cout), 64'(v.cout));
    check("vec_ovf",  64'(bus.ovf),  64'(v.ovf));
  endtask

  task automatic wide_vec(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic op,
                          input logic [31:0] es, input logic ec, input logic eo);
    w_valid = 1'b1; w_a = a; w_b = b; w_cin = cin; w_op = op;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        w_valid = 1'b0;
        check("s1_valid", 64'(bus1.out_valid), 64'd1);
        check("s1_sum",   64'(bus1.sum),  64'(es));
        check("s1_cout",  64'(bus1.cout), 64'(ec));
        check("s1_ovf",   64'(bus1.ovf),  64'(eo));
      end
      if (e == 2) check("s1_single", 64'(bus1.out_valid), 64'd0);
      if (e == 7) check("s8_early",  64'(bus8.out_valid), 64'd0);
      if (e == 8) begin
        check("s8_valid", 64'(bus8.out_valid), 64'd1);
        check("s8_sum",   64'(bus8.sum),  64'(es));
        check("s8_cout",  64'(bus8.cout), 64'(ec));
        check("s8_ovf",   64'(bus8.ovf),  64'(eo));
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] sa[6], sb[6];
    logic        sc[6], so[6];
    int stale;

    vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op_sub = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum",       64'(bus.sum),       64'd0);
    check("rst_cout",      64'(bus.cout),      64'd0);
    check("rst_ovf",       64'(bus.ovf),       64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_s1_valid",  64'(bus1.out_valid), 64'd0);
    check("rst_s8_valid",  64'(bus8.out_valid), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, one at a time
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    @(posedge clk); #1;

    // Back-to-back random stream
    mon_en = 1'b1;
    n_out  = 0;
    for (int i = 0; i < 16; i++)
      send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    bus.in_valid = 1'b0;
    wait_drain();
    check("b2b_count",   64'(n_out), 64'd16);
    check("b2b_spacing", 64'(last_t - first_t), 64'd15);

    // Stall: fill the pipe with out_ready low, then hold for 5 cycles
    for (int i = 0; i < 6; i++) begin
      sa[i] = 16'($urandom_range(0, 65535)); sb[i] = 16'($urandom_range(0, 65535));
      sc[i] = 1'($urandom_range(0, 1));      so[i] = 1'($urandom_range(0, 1));
    end
    n_out = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(sa[i], sb[i], sc[i], so[i]);
    bus.in_valid = 1'b1; bus.a = sa[4]; bus.b = sb[4]; bus.cin = sc[4]; bus.op_sub = so[4];
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready",  64'(bus.in_ready),  64'd0);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_result",    64'({bus.cout, bus.ovf, bus.sum}), 64'(exp_q[0]));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(sa[4], sb[4], sc[4], so[4]);
    send(sa[5], sb[5], sc[5], so[5]);
    bus.in_valid = 1'b0;
    wait_drain();
    check("stall_count", 64'(n_out), 64'd6);

    // Reset with beats in flight
    mon_en = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    send(16'h0F0F, 16'h0101, 1'b1, 1'b1);
    send(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_sum",       64'(bus.sum),       64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("stale_after_reset", 64'(stale), 64'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    n_out  = 0;
    send(16'h4000, 16'h4000, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    wait_drain();
    check("post_rst_count", 64'(n_out), 64'd1);
    mon_en = 1'b0;

    // Wide and single-stage builds
    wide_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    wide_vec(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wide_vec(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
